// File: rtl/cache_meta_pkg.sv
// Shared types and geometry for the cache metadata controller.
package cache_meta_pkg;

  localparam int unsigned NUM_SETS = 256;
  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned WAY_W    = 2;
  localparam int unsigned META_W   = 11;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] dirty;
    logic [2:0] plru;  // {p2, p1, p0}
  } meta_t;

  typedef enum logic [1:0] {
    OpAccess = 2'd0,
    OpFill   = 2'd1,
    OpInval  = 2'd2,
    OpRsvd   = 2'd3
  } meta_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StUpd  = 3'd2,
    StFRd  = 3'd3,
    StFChk = 3'd4,
    StFWb  = 3'd5,
    StFWr  = 3'd6
  } state_e;

endpackage

// File: rtl/metadata_ctrl_if.sv
// Request/response, flush and writeback signals between cache pipeline and metadata_ctrl.
interface metadata_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_idx;
  logic [1:0] req_way;
  logic       req_dirty;

  logic        rsp_valid;
  logic [1:0]  rsp_way;
  logic        rsp_victim_dirty;
  logic [10:0] rsp_meta;

  logic       flush_start;
  logic       flush_busy;
  logic       flush_done;

  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_idx;
  logic [1:0] wb_way;

  modport master (
    output req_valid, req_op, req_idx, req_way, req_dirty, flush_start, wb_ready,
    input  req_ready, rsp_valid, rsp_way, rsp_victim_dirty, rsp_meta,
           flush_busy, flush_done, wb_valid, wb_idx, wb_way
  );

  modport slave (
    input  req_valid, req_op, req_idx, req_way, req_dirty, flush_start, wb_ready,
    output req_ready, rsp_valid, rsp_way, rsp_victim_dirty, rsp_meta,
           flush_busy, flush_done, wb_valid, wb_idx, wb_way
  );
endinterface

// File: rtl/plru4.sv
// 4-way tree-PLRU: victim selection (lowest invalid way first) and touch update.
module plru4 (
  input  logic [2:0] plru,
  input  logic [3:0] valid,
  input  logic [1:0] touch_way,
  output logic [1:0] victim,
  output logic [2:0] plru_touched
);

  always_comb begin
    if (!valid[0]) begin
      victim = 2'd0;
    end else if (!valid[1]) begin
      victim = 2'd1;
    end else if (!valid[2]) begin
      victim = 2'd2;
    end else if (!valid[3]) begin
      victim = 2'd3;
    end else if (!plru[0]) begin
      victim = {1'b0, plru[1]};
    end else begin
      victim = {1'b1, plru[2]};
    end
  end

  always_comb begin
    plru_touched = plru;
    if (!touch_way[1]) begin
      plru_touched[0] = 1'b1;
      plru_touched[1] = ~touch_way[0];
    end else begin
      plru_touched[0] = 1'b0;
      plru_touched[2] = ~touch_way[0];
    end
  end

endmodule

// File: rtl/metadata_ctrl.sv
// Read-modify-write sequencer for the 256x11 cache metadata array.
// Define META_FLUSH_EN to build the dirty-line flush sweep.
module metadata_ctrl
  import cache_meta_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  metadata_ctrl_if.slave bus,
  output logic [7:0]  arr_rd_addr,
  output logic [7:0]  arr_wr_addr,
  output logic        arr_wr_en,
  output logic [10:0] arr_wdata,
  input  logic [10:0] arr_rdata
);

  state_e     state_q, state_d;
  meta_op_e   op_q;
  logic [7:0] idx_q;
  logic [1:0] way_q;
  logic       dirty_q;
  meta_t      meta_q;
  meta_t      meta_new;
  logic       accept;

  logic        rsp_valid_q;
  logic [1:0]  rsp_way_q;
  logic        rsp_vd_q;
  logic [10:0] rsp_meta_q;

  logic [1:0] victim;
  logic [1:0] upd_way;
  logic [2:0] plru_touched;
  logic       is_fill;

  assign is_fill = (op_q == OpFill);
  assign upd_way = is_fill ? victim : way_q;

  plru4 u_plru4 (
    .plru         (meta_q.plru),
    .valid        (meta_q.valid),
    .touch_way    (upd_way),
    .victim       (victim),
    .plru_touched (plru_touched)
  );

  always_comb begin
    meta_new = meta_q;
    case (op_q)
      OpFill: begin
        meta_new.valid[victim] = 1'b1;
        meta_new.dirty[victim] = dirty_q;
        meta_new.plru          = plru_touched;
      end
      OpInval: begin
        meta_new.valid[way_q] = 1'b0;
        meta_new.dirty[way_q] = 1'b0;
      end
      default: begin  // ACCESS and the reserved encoding
        meta_new.dirty[way_q] = meta_q.dirty[way_q] | dirty_q;
        meta_new.plru         = plru_touched;
      end
    endcase
  end

`ifdef META_FLUSH_EN
  logic [7:0] fidx_q, fidx_d;
  logic [1:0] fway_q, fway_d;
  logic       done_q, done_d;
  meta_t      rmeta;

  assign rmeta = meta_t'(arr_rdata);
`endif

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    arr_rd_addr   = '0;
    arr_wr_addr   = '0;
    arr_wr_en     = 1'b0;
    arr_wdata     = '0;
`ifdef META_FLUSH_EN
    fidx_d       = fidx_q;
    fway_d       = fway_q;
    done_d       = 1'b0;
    bus.wb_valid = 1'b0;
`endif
    case (state_q)
      StIdle: begin
`ifdef META_FLUSH_EN
        if (bus.flush_start) begin
          state_d = StFRd;
          fidx_d  = '0;
          fway_d  = '0;
        end else begin
          bus.req_ready = 1'b1;
          accept        = bus.req_valid;
        end
`else
        bus.req_ready = 1'b1;
        accept        = bus.req_valid;
`endif
        if (accept) begin
          arr_rd_addr = bus.req_idx;
          state_d     = StRd;
        end
      end
      StRd: begin
        arr_rd_addr = idx_q;
        state_d     = StUpd;
      end
      StUpd: begin
        arr_rd_addr = idx_q;
        arr_wr_en   = 1'b1;
        arr_wr_addr = idx_q;
        arr_wdata   = meta_new;
        state_d     = StIdle;
      end
`ifdef META_FLUSH_EN
      // Read address stays on fidx for the whole set so arr_rdata remains valid.
      StFRd: begin
        arr_rd_addr = fidx_q;
        state_d     = StFChk;
      end
      StFChk: begin
        arr_rd_addr = fidx_q;
        if (rmeta.valid[fway_q] && rmeta.dirty[fway_q]) begin
          state_d = StFWb;
        end else if (fway_q == 2'd3) begin
          state_d = StFWr;
        end else begin
          fway_d = fway_q + 2'd1;
        end
      end
      StFWb: begin
        arr_rd_addr  = fidx_q;
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) begin
          if (fway_q == 2'd3) begin
            state_d = StFWr;
          end else begin
            fway_d  = fway_q + 2'd1;
            state_d = StFChk;
          end
        end
      end
      StFWr: begin
        arr_rd_addr = fidx_q;
        arr_wr_en   = 1'b1;
        arr_wr_addr = fidx_q;
        arr_wdata   = {rmeta.valid, 4'b0000, rmeta.plru};
        fway_d      = '0;
        if (fidx_q == 8'd255) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          fidx_d  = fidx_q + 8'd1;
          state_d = StFRd;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpAccess;
      idx_q       <= '0;
      way_q       <= '0;
      dirty_q     <= 1'b0;
      meta_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_vd_q    <= 1'b0;
      rsp_meta_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_q == StUpd);
      if (accept) begin
        op_q    <= meta_op_e'(bus.req_op);
        idx_q   <= bus.req_idx;
        way_q   <= bus.req_way;
        dirty_q <= bus.req_dirty;
      end
      if (state_q == StRd) begin
        meta_q <= meta_t'(arr_rdata);
      end
      if (state_q == StUpd) begin
        rsp_way_q  <= upd_way;
        rsp_vd_q   <= is_fill & meta_q.valid[victim] & meta_q.dirty[victim];
        rsp_meta_q <= meta_q;
      end
    end
  end

  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_way          = rsp_way_q;
  assign bus.rsp_victim_dirty = rsp_vd_q;
  assign bus.rsp_meta         = rsp_meta_q;

`ifdef META_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fidx_q <= '0;
      fway_q <= '0;
      done_q <= 1'b0;
    end else begin
      fidx_q <= fidx_d;
      fway_q <= fway_d;
      done_q <= done_d;
    end
  end

  assign bus.flush_busy = (state_q == StFRd) || (state_q == StFChk) ||
                          (state_q == StFWb) || (state_q == StFWr);
  assign bus.flush_done = done_q;
  assign bus.wb_idx     = fidx_q;
  assign bus.wb_way     = fway_q;
`else
  assign bus.flush_busy = 1'b0;
  assign bus.flush_done = 1'b0;
  assign bus.wb_valid   = 1'b0;
  assign bus.wb_idx     = '0;
  assign bus.wb_way     = '0;
`endif

endmodule

// File: tb/tb_metadata_ctrl.sv
// Directed bench for metadata_ctrl with a registered-read array model.
module tb_metadata_ctrl;
  import cache_meta_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  metadata_ctrl_if bus ();

  logic [7:0]  rd_addr, wr_addr;
  logic        wr_en;
  logic [10:0] wdata, rdata;
  logic [10:0] mem [256];

  metadata_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .arr_rd_addr (rd_addr),
    .arr_wr_addr (wr_addr),
    .arr_wr_en   (wr_en),
    .arr_wdata   (wdata),
    .arr_rdata   (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      rdata <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wdata;
    end
  end

  int wr_cnt = 0;
  int rsp_cnt = 0;
  always_ff @(posedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic do_req(input logic [1:0] op, input logic [7:0] idx, input logic [1:0] way,
                        input logic d, output logic [1:0] r_way, output logic r_vd,
                        output logic [10:0] r_meta, output int lat, output logic busy_ok);
    logic got;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_idx   = idx;
    bus.req_way   = way;
    bus.req_dirty = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    busy_ok = !bus.req_ready;
    lat = 0;
    got = 1'b0;
    r_way = 'x; r_vd = 'x; r_meta = 'x;
    while (!got && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) begin
        got    = 1'b1;
        r_way  = bus.rsp_way;
        r_vd   = bus.rsp_victim_dirty;
        r_meta = bus.rsp_meta;
      end else if (bus.req_ready) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_meta !== 11'h000) $display("FAIL reset_rsp_meta got=%h exp=000", bus.rsp_meta); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", wr_en); else n_pass++;
    n_checks++; if ({bus.flush_busy, bus.flush_done, bus.wb_valid} !== 3'b000)
      $display("FAIL reset_flush got=%b exp=000", {bus.flush_busy, bus.flush_done, bus.wb_valid}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_sequence();
    logic [1:0]  exp_way  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [10:0] exp_old  [5] = '{11'h000, 11'h083, 11'h181, 11'h384, 11'h780};
    logic [10:0] exp_new  [5] = '{11'h083, 11'h181, 11'h384, 11'h780, 11'h783};
    logic [1:0] w; logic vd; logic [10:0] m; int lat; logic bok;
    for (int i = 0; i < 5; i++) begin
      do_req(2'd1, 8'd5, 2'd3, 1'b0, w, vd, m, lat, bok);
      n_checks++; if (lat !== 2) $display("FAIL fill%0d_latency got=%0d exp=2", i, lat); else n_pass++;
      n_checks++; if (bok !== 1'b1) $display("FAIL fill%0d_ready_low got=%b exp=1", i, bok); else n_pass++;
      n_checks++; if (w !== exp_way[i]) $display("FAIL fill%0d_way got=%0d exp=%0d", i, w, exp_way[i]); else n_pass++;
      n_checks++; if (vd !== 1'b0) $display("FAIL fill%0d_victim_dirty got=%b exp=0", i, vd); else n_pass++;
      n_checks++; if (m !== exp_old[i]) $display("FAIL fill%0d_rsp_meta got=%h exp=%h", i, m, exp_old[i]); else n_pass++;
      n_checks++; if (mem[5] !== exp_new[i]) $display("FAIL fill%0d_array got=%h exp=%h", i, mem[5], exp_new[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops   [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic [1:0]  ways  [4] = '{2'd2, 2'd3, 2'd0, 2'd0};
    logic        dirt  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  e_way [4] = '{2'd2, 2'd3, 2'd0, 2'd2};
    logic        e_vd  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [10:0] e_old [4] = '{11'h783, 11'h7A6, 11'h7A2, 11'h7A3};
    logic [10:0] e_new [4] = '{11'h7A6, 11'h7A2, 11'h7A3, 11'h786};
    logic [1:0] w; logic vd; logic [10:0] m; int lat; logic bok;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], 8'd5, ways[i], dirt[i], w, vd, m, lat, bok);
      n_checks++; if (w !== e_way[i]) $display("FAIL b2b%0d_way got=%0d exp=%0d", i, w, e_way[i]); else n_pass++;
      n_checks++; if (vd !== e_vd[i]) $display("FAIL b2b%0d_victim_dirty got=%b exp=%b", i, vd, e_vd[i]); else n_pass++;
      n_checks++; if (m !== e_old[i]) $display("FAIL b2b%0d_rsp_meta got=%h exp=%h", i, m, e_old[i]); else n_pass++;
      n_checks++; if (mem[5] !== e_new[i]) $display("FAIL b2b%0d_array got=%h exp=%h", i, mem[5], e_new[i]); else n_pass++;
    end
  endtask

  task automatic test_inval();
    logic [1:0] w; logic vd; logic [10:0] m; int lat; logic bok;
    do_req(2'd2, 8'd5, 2'd1, 1'b0, w, vd, m, lat, bok);
    n_checks++; if (w !== 2'd1) $display("FAIL inval_way got=%0d exp=1", w); else n_pass++;
    n_checks++; if (m !== 11'h786) $display("FAIL inval_rsp_meta got=%h exp=786", m); else n_pass++;
    n_checks++; if (mem[5] !== 11'h686) $display("FAIL inval_array got=%h exp=686", mem[5]); else n_pass++;
    do_req(2'd1, 8'd5, 2'd0, 1'b1, w, vd, m, lat, bok);
    n_checks++; if (w !== 2'd1) $display("FAIL inval_refill_way got=%0d exp=1", w); else n_pass++;
    n_checks++; if (vd !== 1'b0) $display("FAIL inval_refill_vd got=%b exp=0", vd); else n_pass++;
    n_checks++; if (mem[5] !== 11'h795) $display("FAIL inval_refill_array got=%h exp=795", mem[5]); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int wr0, rsp0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_idx   = 8'd9;
    bus.req_way   = 2'd0;
    bus.req_dirty = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wr0  = wr_cnt;
    rsp0 = rsp_cnt;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (wr_cnt !== wr0) $display("FAIL rstmid_writes got=%0d exp=%0d", wr_cnt, wr0); else n_pass++;
    n_checks++; if (rsp_cnt !== rsp0) $display("FAIL rstmid_rsp got=%0d exp=%0d", rsp_cnt, rsp0); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", bus.req_ready); else n_pass++;
    n_checks++; if (mem[9] !== 11'h000) $display("FAIL rstmid_array got=%h exp=000", mem[9]); else n_pass++;
  endtask

`ifdef META_FLUSH_EN
  task automatic test_flush();
    logic [1:0] w; logic vd; logic [10:0] m; int lat; logic bok;
    logic [7:0] b_idx [4];
    logic [1:0] b_way [4];
    int beats, done_cnt, ready_bad, cnt, extra;
    do_req(2'd1, 8'd0, 2'd0, 1'b0, w, vd, m, lat, bok);
    do_req(2'd1, 8'd0, 2'd0, 1'b0, w, vd, m, lat, bok);
    do_req(2'd1, 8'd0, 2'd0, 1'b0, w, vd, m, lat, bok);
    do_req(2'd1, 8'd0, 2'd0, 1'b1, w, vd, m, lat, bok);
    do_req(2'd1, 8'd255, 2'd0, 1'b1, w, vd, m, lat, bok);
    beats = 0; done_cnt = 0; ready_bad = 0; cnt = 0; extra = 0;
    @(negedge clk);
    bus.flush_start = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      bus.flush_start = 1'b0;
      bus.wb_ready    = 1'b0;
      if (bus.flush_busy && bus.req_ready) ready_bad++;
      if (bus.wb_valid) begin
        if (cnt == 3) begin
          bus.wb_ready = 1'b1;
          cnt = 0;
          if (beats < 4) begin
            b_idx[beats] = bus.wb_idx;
            b_way[beats] = bus.wb_way;
          end
          beats++;
        end else begin
          cnt++;
        end
      end
      if (bus.flush_done) begin
        done_cnt++;
        n_checks++; if (bus.flush_busy !== 1'b0) $display("FAIL flush_done_busy got=%b exp=0", bus.flush_busy); else n_pass++;
      end
      if (done_cnt > 0) extra++;
      if (extra > 10) break;
    end
    n_checks++; if (beats !== 2) $display("FAIL flush_beats got=%0d exp=2", beats); else n_pass++;
    n_checks++; if ({b_idx[0], b_way[0]} !== {8'd0, 2'd3})
      $display("FAIL flush_beat0 got=%0d/%0d exp=0/3", b_idx[0], b_way[0]); else n_pass++;
    n_checks++; if ({b_idx[1], b_way[1]} !== {8'd255, 2'd0})
      $display("FAIL flush_beat1 got=%0d/%0d exp=255/0", b_idx[1], b_way[1]); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL flush_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
    n_checks++; if (ready_bad !== 0) $display("FAIL flush_ready_low got=%0d exp=0", ready_bad); else n_pass++;
    n_checks++; if (mem[0] !== 11'h780) $display("FAIL flush_set0 got=%h exp=780", mem[0]); else n_pass++;
    n_checks++; if (mem[255] !== 11'h083) $display("FAIL flush_set255 got=%h exp=083", mem[255]); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL flush_ready_after got=%b exp=1", bus.req_ready); else n_pass++;
  endtask
`else
  task automatic test_flush_disabled();
    @(negedge clk);
    bus.flush_start = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL noflush_ready got=%b exp=1", bus.req_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.flush_busy, bus.flush_done, bus.wb_valid} !== 3'b000)
        $display("FAIL noflush_outs%0d got=%b exp=000", i, {bus.flush_busy, bus.flush_done, bus.wb_valid});
      else n_pass++;
    end
    bus.flush_start = 1'b0;
  endtask
`endif

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'd0;
    bus.req_idx     = 8'd0;
    bus.req_way     = 2'd0;
    bus.req_dirty   = 1'b0;
    bus.flush_start = 1'b0;
    bus.wb_ready    = 1'b0;
    test_reset();
    test_fill_sequence();
    test_back_to_back();
    test_inval();
    test_reset_mid_op();
`ifdef META_FLUSH_EN
    test_flush();
`else
    test_flush_disabled();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
